abus_arbiter: RTL and testbench

Shares the 19-bit A bus between up to NREQ datapath requesters (control unit, memory interface, address generator, debug port) by deciding each cycle which requester's 4-bit source code drives A_SEL into the abus mux. It has a registered grant with round-robin priority, optional multi-cycle bus locking, and a hold limit that stops any locked owner from starving the others. It sits between the requesters and the abus mux. When the bus is idle it drives `asel_none`.

---
 rtl/abus_arbiter.sv | 121 ++++++++++++
 tb/tb_abus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/abus_arbiter.sv
// abus_arbiter: registered grant of the shared A bus to one of NREQ requesters, with lock and hold limit.
// Define ABUS_RR_EN for round-robin priority; without it the lowest requesting index wins every arbitration.
module abus_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDW       = 2,
    parameter int unsigned MAX_HOLD  = 15,
    parameter logic [3:0]  ASEL_NONE = 4'h0   // asel_none code of the abus mux
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [4*NREQ-1:0] sel,
    output logic [NREQ-1:0]   gnt,
    output logic [IDW-1:0]    owner,
    output logic              busy,
    output logic [3:0]        A_SEL
);

    localparam int unsigned    HCW      = 8;
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

    logic [HCW-1:0]  hold_q;
    logic [HCW-1:0]  hold_d;
    logic [NREQ-1:0] gnt_d;
    logic [IDW-1:0]  owner_d;
    logic            busy_d;
    logic [NREQ-1:0] cand;
    logic            others;
    logic            at_limit;
    logic            retain;
    logic            found;
    logic [IDW-1:0]  win;
    int unsigned     idx;

`ifdef ABUS_RR_EN
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
`endif

    // Ownership status: retain while locked and under the hold limit
    always_comb begin
        others   = |(req & ~gnt);
        at_limit = (hold_q >= HOLD_MAX);
        retain   = busy && req[owner] && lock[owner] && !at_limit;
        cand     = req;
        if (busy && at_limit && others) begin
            cand = req & ~gnt;
        end
    end

    // Winner search over the candidate set, starting from the pointer
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ABUS_RR_EN
            idx = (32'(ptr_q) + k) % NREQ;
`else
            idx = k;
`endif
            if (!found && cand[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Next grant state
    always_comb begin
        gnt_d   = gnt;
        owner_d = owner;
        busy_d  = busy;
        hold_d  = hold_q;
`ifdef ABUS_RR_EN
        ptr_d   = ptr_q;
`endif
        if (retain) begin
            hold_d = (hold_q == '1) ? hold_q : hold_q + HCW'(1);
        end else if (found) begin
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            owner_d    = win;
            busy_d     = 1'b1;
            hold_d     = HCW'(1);
`ifdef ABUS_RR_EN
            ptr_d      = (32'(win) == NREQ - 1) ? '0 : win + IDW'(1);
`endif
        end else begin
            gnt_d   = '0;
            owner_d = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt    <= '0;
            owner  <= '0;
            busy   <= 1'b0;
            hold_q <= '0;
`ifdef ABUS_RR_EN
            ptr_q  <= '0;
`endif
        end else begin
            gnt    <= gnt_d;
            owner  <= owner_d;
            busy   <= busy_d;
            hold_q <= hold_d;
`ifdef ABUS_RR_EN
            ptr_q  <= ptr_d;
`endif
        end
    end

    // Live source code of the registered owner; the mux consumes it in the same cycle
    assign A_SEL = busy ? sel[{owner, 2'b00} +: 4] : ASEL_NONE;

endmodule

// File: tb/tb_abus_arbiter.sv
// Self-checking bench for abus_arbiter: directed tables and sequences plus random traffic against a queue-based model.
module tb_abus_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned MH   = 15;
    localparam logic [3:0]  NONE = 4'h0;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [15:0] sel;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  A_SEL;

    int total = 0;
    int bad   = 0;

    // Reference model state: owner index (-1 idle), consecutive hold cycles, rotation start
    int m_owner;
    int m_hold;
    int m_ptr;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        int         owner;
        bit         busy;
    } vec_t;

    vec_t tbl[12];
    logic [3:0] req_tab[12] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                4'h0, 4'h8, 4'h6, 4'h6};
`ifdef ABUS_RR_EN
    int own_tab[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3, 1, 2};
`else
    int own_tab[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1};
`endif

    abus_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAX_HOLD(MH), .ASEL_NONE(NONE)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req),
        .lock  (lock),
        .sel   (sel),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .A_SEL (A_SEL)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
    endfunction

    // One clock edge of the arbitration rules, expressed as a priority-ordered list of eligible requesters
    function automatic void model_edge(input logic [3:0] r, input logic [3:0] l);
        int waiting;
        int order[$];
        int id;
        waiting = 0;
        for (int i = 0; i < 4; i++) if (r[i] && i != m_owner) waiting++;
        if (m_owner >= 0 && r[m_owner] && l[m_owner] && m_hold < int'(MH)) begin
            m_hold++;
            return;
        end
        order = {};
        for (int k = 0; k < 4; k++) begin
`ifdef ABUS_RR_EN
            id = (m_ptr + k) % 4;
`else
            id = k;
`endif
            if (r[id] && !(id == m_owner && m_hold >= int'(MH) && waiting > 0))
                order.push_back(id);
        end
        if (order.size() == 0) begin
            m_owner = -1;
            m_hold  = 0;
        end else begin
            m_owner = order[0];
            m_hold  = 1;
            m_ptr   = (m_owner + 1) % 4;
        end
    endfunction

    task automatic check_model(input string tag);
        logic [3:0] eg;
        logic [3:0] ea;
        logic [1:0] eo;
        logic       eb;
        if (m_owner < 0) begin
            eg = 4'h0; eo = 2'd0; eb = 1'b0; ea = NONE;
        end else begin
            eg = 4'(1 << m_owner); eo = 2'(m_owner); eb = 1'b1; ea = sel[m_owner*4 +: 4];
        end
        chk({tag, "_gnt"},   32'(gnt),   32'(eg));
        chk({tag, "_owner"}, 32'(owner), 32'(eo));
        chk({tag, "_busy"},  32'(busy),  32'(eb));
        chk({tag, "_asel"},  32'(A_SEL), 32'(ea));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(req, lock);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = 4'h0;
        lock = 4'h0;
        @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;
    endtask

    initial begin
        int held;
        // Reset with every requester asking
        rstn = 1'b0;
        req  = 4'hF;
        lock = 4'h0;
        sel  = 16'h4321;
        model_reset();
        #7;
        chk("rst_gnt",  32'(gnt),   32'h0);
        chk("rst_busy", 32'(busy),  32'h0);
        chk("rst_own",  32'(owner), 32'h0);
        chk("rst_asel", 32'(A_SEL), 32'(NONE));
        rstn = 1'b1;
        step("first");
        chk("first_gnt",  32'(gnt),   32'h1);
        chk("first_asel", 32'(A_SEL), 32'h1);

        // Table: rotation / fixed priority, idle, and pointer-dependent picks
        for (int i = 0; i < 12; i++) begin
            tbl[i].req   = req_tab[i];
            tbl[i].lock  = 4'h0;
            tbl[i].owner = own_tab[i];
            tbl[i].busy  = (i != 8);
        end
        do_reset();
        sel = 16'hDCBA;
        for (int i = 0; i < 12; i++) begin
            req  = tbl[i].req;
            lock = tbl[i].lock;
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_owner_c", i), 32'(owner), 32'(tbl[i].owner));
            chk($sformatf("tbl%0d_busy_c", i),  32'(busy),  32'(tbl[i].busy));
            chk($sformatf("tbl%0d_gnt_c", i),   32'(gnt),
                tbl[i].busy ? 32'(1 << tbl[i].owner) : 32'h0);
        end

        // Locked requester 2 under contention from requester 0
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        held = 0;
        for (int c = 1; c <= 16; c++) begin
            step($sformatf("lk%0d", c));
            req = 4'b0101;
            if (c <= 15) chk($sformatf("lk%0d_owner2", c), 32'(owner), 32'd2);
            else         chk("lk16_owner0", 32'(owner), 32'd0);
            if (owner == 2'd2) held++;
        end
        chk("lk_held_cycles", 32'(held), 32'(MH));

        // Locked requester 1 alone: never drops across hold-count restarts
        do_reset();
        req  = 4'b0010;
        lock = 4'b0010;
        held = 0;
        for (int c = 0; c < 40; c++) begin
            step("alone");
            if (owner == 2'd1 && busy) held++;
        end
        chk("alone_cycles", 32'(held), 32'd40);

        // Release by owner 3, then handover without a gap
        do_reset();
        sel = 16'hA987;
        req = 4'b1000;
        step("rel_a");
        req = 4'b0000;
        #1;
        chk("rel_asel_live", 32'(A_SEL), 32'hA);
        chk("rel_gnt_live",  32'(gnt),   32'h8);
        step("rel_b");
        chk("rel_busy_off", 32'(busy), 32'h0);
        req = 4'b1000;
        step("hand_a");
        req = 4'b0001;
        step("hand_b");
        chk("hand_owner0", 32'(owner), 32'd0);
        chk("hand_busy",   32'(busy),  32'h1);

        // Asynchronous reset in the middle of a locked grant
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        step("ar_a");
        step("ar_b");
        step("ar_c");
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_gnt",  32'(gnt),   32'h0);
        chk("ar_busy", 32'(busy),  32'h0);
        chk("ar_own",  32'(owner), 32'h0);
        chk("ar_asel", 32'(A_SEL), 32'(NONE));
        model_reset();
        rstn = 1'b1;
        req  = 4'hF;
        lock = 4'h0;
        step("ar_d");
        chk("ar_ptr0_owner", 32'(owner), 32'd0);

        // Random traffic with mostly-held requests and frequent locks
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            lock = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            sel  = 16'($urandom);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
